// File: rtl/axi3_pkg.sv
// rtl/axi3_pkg.sv - shared burst/response codes, widths and FSM state type for the AXI3 bridge
package axi3_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_DATA
    } state_t;

endpackage

// File: rtl/axi3_burst_addr.sv
// rtl/axi3_burst_addr.sv - next word address for FIXED/INCR/WRAP bursts
module axi3_burst_addr
    import axi3_pkg::*;
(
    input  logic [ADDR_W-3:0] addr,
    input  logic [3:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-3:0] next_addr
);

    logic [ADDR_W-3:0] incr;
    logic [ADDR_W-3:0] wrap_mask;

    always_comb begin
        incr      = addr + 30'd1;
        // legal wrap lengths are 2/4/8/16 beats, so len itself is the in-block offset mask
        wrap_mask = {{(ADDR_W-6){1'b0}}, len};
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:     next_addr = incr;
        endcase
    end

endmodule

// File: rtl/axi3_to_intbus.sv
// rtl/axi3_to_intbus.sv - AXI3 slave to single-cycle internal register bus bridge, one beat at a time
module axi3_to_intbus
    import axi3_pkg::*;
#(
    parameter int ID_W         = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,

    input  logic [ID_W-1:0]   wid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,

    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,

    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    output logic [ADDR_W-3:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_wr,
    output logic              bus_rd,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_t            state_q, state_d;
    logic [ADDR_W-3:0] cur_addr;
    logic [ADDR_W-3:0] next_addr;
    logic [3:0]        len_q;
    logic [3:0]        beat_q;
    logic [1:0]        burst_q;
    logic [2:0]        lat_q;
    logic              last_beat;
    logic              unused_inputs;

    assign last_beat     = (beat_q == len_q);
    assign unused_inputs = ^{wid, wstrb, awsize, arsize, awaddr[1:0], araddr[1:0]};

    axi3_burst_addr u_burst_addr (
        .addr      (cur_addr),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        case (state_q)
            IDLE: begin
                // readies stay low while reset is held; a write wins a same-cycle tie
                awready = !areset;
                arready = !areset && !awvalid;
                if (awvalid)      state_d = WR_DATA;
                else if (arvalid) state_d = RD_ISSUE;
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) state_d = WR_RESP;
            end
            WR_RESP:  if (bready) state_d = IDLE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  if (lat_q == LAT) state_d = RD_DATA;
            RD_DATA:  if (rready) state_d = last_beat ? IDLE : RD_ISSUE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cur_addr  <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            bid       <= '0;
            bresp     <= RESP_OKAY;
            bvalid    <= 1'b0;
            rid       <= '0;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
            rlast     <= 1'b0;
            rvalid    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wr    <= 1'b0;
            bus_rd    <= 1'b0;
        end else begin
            bus_wr <= 1'b0;
            bus_rd <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (awvalid) begin
                        bid      <= awid;
                        cur_addr <= awaddr[ADDR_W-1:2];
                        len_q    <= awlen;
                        burst_q  <= awburst;
                    end else if (arvalid) begin
                        rid      <= arid;
                        cur_addr <= araddr[ADDR_W-1:2];
                        bus_addr <= araddr[ADDR_W-1:2];
                        len_q    <= arlen;
                        burst_q  <= arburst;
                        beat_q   <= '0;
                        bus_rd   <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        bus_wr    <= 1'b1;
                        bus_addr  <= cur_addr;
                        bus_wdata <= wdata;
                        cur_addr  <= next_addr;
                        if (wlast) begin
                            bvalid <= 1'b1;
                            bresp  <= RESP_OKAY;
                        end
                    end
                end
                WR_RESP: if (bready) bvalid <= 1'b0;
                RD_ISSUE: lat_q <= 3'd1;
                RD_WAIT: begin
                    lat_q <= lat_q + 3'd1;
                    if (lat_q == LAT) begin
                        rdata  <= bus_rdata;
                        rvalid <= 1'b1;
                        rresp  <= RESP_OKAY;
                        rlast  <= last_beat;
                    end
                end
                RD_DATA: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (!last_beat) begin
                            cur_addr <= next_addr;
                            bus_addr <= next_addr;
                            beat_q   <= beat_q + 4'd1;
                            bus_rd   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi3_to_intbus.sv
// tb/tb_axi3_to_intbus.sv - randomized self-checking bench for axi3_to_intbus
module tb_axi3_to_intbus;

    localparam int ID_W = 12;
    localparam int LAT  = 2;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [ID_W-1:0] awid, wid, bid, arid, rid;
    logic [31:0]     awaddr, araddr, wdata, rdata, bus_wdata, bus_rdata;
    logic [3:0]      awlen, arlen, wstrb;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready, bus_wr, bus_rd;
    logic [29:0]     bus_addr;

    axi3_to_intbus #(.ID_W(ID_W), .READ_LATENCY(LAT)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_rdata(bus_rdata)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // register-bus slave: sparse memory, read data only valid exactly LAT cycles after bus_rd
    logic [31:0] mem [logic [29:0]];
    logic [29:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [29:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    int          rd_due = -1;
    logic [31:0] rd_val;
    int          n_overlap = 0;

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return {2'b01, a} ^ 32'h5A5A_0000;
    endfunction

    always @(negedge aclk) begin
        if (bus_wr) begin
            wr_addr_q.push_back(bus_addr);
            wr_data_q.push_back(bus_wdata);
            wr_cyc_q.push_back(cyc);
            mem[bus_addr] = bus_wdata;
        end
        if (bus_rd) begin
            rd_addr_q.push_back(bus_addr);
            rd_cyc_q.push_back(cyc);
            rd_due = cyc + LAT;
            rd_val = mem_rd(bus_addr);
        end
        if (bus_wr && bus_rd) n_overlap++;
        bus_rdata = (cyc == rd_due) ? rd_val : $urandom;
    end

    function automatic logic [29:0] model_next(input logic [29:0] a, input int len, input logic [1:0] burst);
        longint sz, base, off;
        sz = len + 1;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            base = (longint'(a) / sz) * sz;
            off  = (longint'(a) - base + 1) % sz;
            return 30'(base + off);
        end
        return a + 30'd1;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_aw(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, output int hs_cyc);
        logic rdy;
        int   c;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        hs_cyc = -1;
        for (int n = 0; n < 300; n++) begin
            #1; rdy = awready; c = cyc;
            tick();
            if (rdy) begin hs_cyc = c; break; end
        end
        awvalid = 1'b0;
        check_eq("aw_hs", hs_cyc >= 0, 1);
    endtask

    task automatic send_ar(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, output int hs_cyc);
        logic rdy;
        int   c;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        hs_cyc = -1;
        for (int n = 0; n < 300; n++) begin
            #1; rdy = arready; c = cyc;
            tick();
            if (rdy) begin hs_cyc = c; break; end
        end
        arvalid = 1'b0;
        check_eq("ar_hs", hs_cyc >= 0, 1);
    endtask

    task automatic send_w(input logic [31:0] data, input logic last, input int gap);
        logic rdy;
        int   hs;
        repeat (gap) tick();
        wvalid = 1'b1; wdata = data; wlast = last; wid = ID_W'($urandom); wstrb = 4'($urandom);
        hs = 0;
        for (int n = 0; n < 300; n++) begin
            #1; rdy = wready;
            tick();
            if (rdy) begin hs = 1; break; end
        end
        wvalid = 1'b0; wlast = 1'b0;
        check_eq("w_hs", hs, 1);
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int gapmax, input int bdelay,
                            output int aw_c, output int b_c);
        logic [31:0] d [16];
        logic [29:0] ea [16];
        logic [29:0] a;
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        send_aw(id, addr, 4'(len), burst, aw_c);
        a = addr[31:2];
        for (int i = 0; i <= len; i++) begin
            d[i] = $urandom; ea[i] = a;
            a = model_next(a, len, burst);
            send_w(d[i], i == len, $urandom_range(0, gapmax));
        end
        b_c = -1;
        for (int n = 0; n < 300; n++) begin
            if (bvalid) begin b_c = cyc; break; end
            tick();
        end
        check_eq("b_seen", b_c >= 0, 1);
        if (b_c >= 0) begin
            for (int k = 0; k < bdelay; k++) begin
                check_eq("b_hold", {bvalid, awready, bid}, {1'b1, 1'b0, id});
                tick();
            end
            check_eq("b_payload", {bid, bresp}, {id, 2'b00});
            bready = 1'b1; tick(); bready = 1'b0;
            check_eq("b_drop", bvalid, 0);
        end
        check_eq("wr_count", wr_addr_q.size(), len + 1);
        for (int i = 0; i <= len && i < wr_addr_q.size(); i++)
            check_eq($sformatf("wr_beat%0d", i), {wr_addr_q[i], wr_data_q[i]}, {ea[i], d[i]});
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int smin, input int smax,
                           output int ar_c, output int rv_c);
        logic [29:0] ea [16];
        logic [29:0] a;
        logic [31:0] exp;
        int          rv, stall;
        rd_addr_q.delete(); rd_cyc_q.delete();
        send_ar(id, addr, 4'(len), burst, ar_c);
        a = addr[31:2];
        rv_c = -1;
        for (int i = 0; i <= len; i++) begin
            ea[i] = a;
            rv = -1;
            for (int n = 0; n < 300; n++) begin
                if (rvalid) begin rv = cyc; break; end
                tick();
            end
            check_eq("r_seen", rv >= 0, 1);
            if (rv < 0) break;
            if (i == 0) rv_c = rv;
            exp = mem_rd(a);
            stall = $urandom_range(smin, smax);
            for (int k = 0; k < stall; k++) begin
                check_eq("r_hold", {rvalid, arready, rdata}, {1'b1, 1'b0, exp});
                tick();
            end
            check_eq($sformatf("r_beat%0d", i), {rdata, rid, rresp, rlast},
                     {exp, id, 2'b00, 1'(i == len)});
            rready = 1'b1; tick(); rready = 1'b0;
            check_eq("r_drop", rvalid, 0);
            a = model_next(a, len, burst);
        end
        check_eq("rd_count", rd_addr_q.size(), len + 1);
        for (int i = 0; i <= len && i < rd_addr_q.size(); i++)
            check_eq($sformatf("rd_addr%0d", i), rd_addr_q[i], ea[i]);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int aw_c, b_c, ar_c, rv_c, bv_seen;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_eq("rst_handshake", {awready, arready, wready, bvalid, rvalid}, 0);
        check_eq("rst_bus", {bus_wr, bus_rd, bus_addr, bus_wdata}, 0);
        check_eq("rst_resp", {rlast, bresp, rresp, bid, rid}, 0);
        check_eq("rst_rdata", rdata, 0);
        areset = 1'b0;
        tick();
        check_eq("idle_ready", {awready, arready, wready}, 3'b110);

        // single write, then single read of the XADC word
        do_write(12'h5, 32'h4000_00F8, 0, 2'b01, 0, 0, aw_c, b_c);
        check_eq("wr1_b_lat", b_c - aw_c, 2);
        if (wr_cyc_q.size() > 0) check_eq("wr1_bus_lat", wr_cyc_q[0] - aw_c, 2);
        check_eq("wr1_mem", mem_rd(30'h1000_003E), 32'hDEAD_BEEF ^ 32'hDEAD_BEEF ^ wr_data_q[0]);
        mem[30'h1000_003E] = 32'h1234_5678;
        do_read(12'h7, 32'h4000_00F8, 0, 2'b01, 0, 0, ar_c, rv_c);
        check_eq("rd1_rv_lat", rv_c - ar_c, 2 + LAT);
        if (rd_cyc_q.size() > 0) check_eq("rd1_bus_lat", rd_cyc_q[0] - ar_c, 1);

        // INCR write of four beats, then confirm only one B response
        do_write(12'h9, 32'h4000_0000, 3, 2'b01, 0, 1, aw_c, b_c);
        bv_seen = 0;
        repeat (4) begin tick(); bv_seen += int'(bvalid); end
        check_eq("incr_single_b", bv_seen, 0);

        // FIXED read, free-flowing and with rready held off three cycles
        do_read(12'h21, 32'h4000_0010, 1, 2'b00, 0, 0, ar_c, rv_c);
        do_read(12'h22, 32'h4000_0010, 1, 2'b00, 3, 3, ar_c, rv_c);

        // same-cycle AW and AR to one address: write must finish first
        fork
            do_write(12'h31, 32'h4000_0200, 0, 2'b01, 1, 2, aw_c, b_c);
            do_read(12'h32, 32'h4000_0200, 0, 2'b01, 0, 1, ar_c, rv_c);
        join
        check_eq("tie_order", ar_c > b_c, 1);

        // reset after two of four INCR beats
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        send_aw(12'h3, 32'h4000_0100, 4'd3, 2'b01, aw_c);
        send_w(32'hA0A0_0001, 1'b0, 0);
        send_w(32'hA0A0_0002, 1'b0, 0);
        tick();
        #1 areset = 1'b1;
        #1;
        check_eq("rst_mid_ctrl", {bvalid, rvalid, wready, awready, arready, bus_wr, bus_rd}, 0);
        check_eq("rst_mid_bus", {bus_addr, bus_wdata}, 0);
        tick(); tick();
        areset = 1'b0;
        wvalid = 1'b1; wdata = 32'hBAD0_BAD0;
        bv_seen = 0;
        repeat (6) begin tick(); bv_seen += int'(bvalid); end
        wvalid = 1'b0;
        check_eq("rst_no_b", bv_seen, 0);
        check_eq("rst_wr_count", wr_addr_q.size(), 2);
        do_write(12'h44, 32'h4000_0300, 1, 2'b01, 0, 0, aw_c, b_c);

        // randomized mix of bursts
        for (int t = 0; t < 40; t++) begin
            int          len;
            logic [1:0]  burst;
            logic [31:0] addr;
            logic [ID_W-1:0] id;
            burst = 2'($urandom_range(0, 3));
            if (burst == 2'b10) len = (1 << $urandom_range(1, 4)) - 1;
            else                len = $urandom_range(0, 7);
            addr = 32'h4000_0000 | (32'($urandom_range(0, 1023)) << 2);
            id   = ID_W'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_write(id, addr, len, burst, 2, $urandom_range(0, 3), aw_c, b_c);
            else
                do_read(id, addr, len, burst, 0, 3, ar_c, rv_c);
            repeat ($urandom_range(0, 2)) tick();
        end

        check_eq("no_overlap", n_overlap, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi3_to_intbus.md
# axi3_to_intbus

AXI3 slave-to-internal-register-bus bridge. It terminates the processor's 32-bit AXI3 general-purpose master port and converts each AXI beat into single-cycle word accesses on the flat internal register bus (intbus) shared by all peripheral register blocks, such as the XADC block at word address 0x1000003E. Transactions are serialized, one at a time; throughput is secondary to simplicity.

## Interface
- Clocking (decided): one clock; reset is asynchronous and active-high.
- `ID_W`, default 12: AXI ID width.
- `READ_LATENCY`, default 2: cycles from `bus_rd` to valid `bus_rdata`, range 1..7.
- `aclk` in 1: bus clock; all logic on its rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `awid` in ID_W, `awaddr` in 32, `awlen` in 4, `awsize` in 3, `awburst` in 2, `awvalid` in 1, `awready` out 1: write address channel.
- `wid` in ID_W, `wdata` in 32, `wstrb` in 4, `wlast` in 1, `wvalid` in 1, `wready` out 1: write data channel.
- `bid` out ID_W, `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `arid` in ID_W, `araddr` in 32, `arlen` in 4, `arsize` in 3, `arburst` in 2, `arvalid` in 1, `arready` out 1: read address channel.
- `rid` out ID_W, `rdata` out 32, `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1: read data channel.
- `bus_addr` out 30: word address, equal to AXI address[31:2].
- `bus_wdata` out 32: write data.
- `bus_wr` out 1: one-cycle write strobe.
- `bus_rd` out 1: one-cycle read strobe.
- `bus_rdata` in 32: OR-combined slave read data, sampled `READ_LATENCY` cycles after `bus_rd`.

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_WAIT, RD_DATA.
- IDLE:
  - `awready`=1.
  - `arready`=!`awvalid`, so a write wins when both are valid in the same cycle.
  - An AW handshake latches id, address, len and burst, then moves to WR_DATA.
  - An AR handshake latches the same fields and moves to RD_ISSUE.
- WR_DATA:
  - `wready`=1.
  - Each W handshake registers `bus_wr`=1, `bus_addr` and `bus_wdata` for the next cycle, then advances the address.
  - `wstrb`, `wid` and `awsize` are ignored; every access is a full 32-bit word.
  - The beat with `wlast`=1 moves to WR_RESP. Beat counting uses `wlast` only.
- WR_RESP: `bvalid`=1, `bresp`=00, `bid`=latched awid. Outputs hold until `bready`, then go to IDLE.
- RD_ISSUE: `bus_rd`=1 for one cycle with the current `bus_addr`, then RD_WAIT.
- RD_WAIT:
  - Counts `READ_LATENCY` cycles, then captures `bus_rdata` into the `rdata` register and moves to RD_DATA.
  - In this state, the cycle after `bus_rd` counts as cycle 1.
- RD_DATA:
  - `rvalid`=1, `rid`=latched arid, `rresp`=00.
  - `rlast`=1 when beat index equals the latched `arlen`.
  - On the `rready` handshake: last beat goes to IDLE; otherwise advance the address and go to RD_ISSUE.
- Address advance:
  - FIXED (00): unchanged.
  - INCR (01): +1 word.
  - WRAP (10): +1 word, wrapping within an aligned block of (len+1) words.
  - Reserved (11): treated as INCR.
- No error responses are generated.

## Timing
- Reset values: all AXI ready/valid outputs 0, `rlast` 0, `bresp`/`rresp` 0, `bid`/`rid`/`rdata` 0, `bus_wr`/`bus_rd` 0, `bus_addr`/`bus_wdata` 0, state IDLE.
- Reset mid-transaction aborts immediately. No B/R response is issued for the aborted transaction.
- All outputs are registered except `awready`, `arready` and `wready`, which decode combinationally from the state (plus `awvalid` for `arready`).
- Single write: AW handshake in cycle N, W handshake at N+1, `bus_wr` at N+2, `bvalid` at N+2.
- Single read: AR handshake in cycle N, `bus_rd` at N+1, `rvalid` at N+2+READ_LATENCY.
- `bvalid`/`rvalid` stay asserted, with payload stable, until accepted. No new address is accepted meanwhile.
- `bus_wr` and `bus_rd` are never high in the same cycle, and each is high for exactly one cycle per beat.

## Structure
- Package `axi3_pkg` holds:
  - burst codes FIXED/INCR/WRAP;
  - response code OKAY;
  - data width 32 and address width 32;
  - the FSM state enum type.
- One sub-module, `axi3_burst_addr`: combinational next-address logic from current word address, len and burst.
- Everything else lives in the top module.

## Test plan
- Write 0xDEADBEEF to 0x400000F8, awid 0x5 -> one `bus_wr` with `bus_addr` 0x1000003E and data 0xDEADBEEF; then `bvalid`, `bresp`=00, `bid`=0x5.
- Read 0x400000F8 with `bus_rdata` returning 0x12345678 at latency 2 -> `rdata` 0x12345678, `rlast`=1, `rvalid` at N+4.
- INCR write, `awlen`=3, address 0x40000000 -> four `bus_wr` at 0x10000000..0x10000003, then exactly one B response.
- FIXED read, `arlen`=1, address 0x40000010 -> two `bus_rd` at 0x10000004; `rlast` only on the second beat. Repeat with `rready` low for 3 cycles: `rvalid`/`rdata` held.
- `awvalid` and `arvalid` asserted in the same cycle -> write completes first, including its B response; the read is serviced afterwards.
- `areset` asserted mid-INCR write after 2 of 4 beats -> no further `bus_wr`, no `bvalid`, all outputs at reset values; the next transaction completes normally.
